// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver: codec ADC I2S stream -> parallel signed L/R pair, valid/ready handshake.
// Ports: clk, reset (async, active-low); aud_bclk/aud_adclrck/aud_adcdat (async serial in);
//   sample_left/right, sample_valid, sample_ready; overrun (sticky), overrun_clear; frame_error (pulse).
//   Build macro I2S_ADC_PEAK_EN adds peak_clear in, peak_left/peak_right out (|sample| max-hold).
module i2s_adc_receiver #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    aud_bclk,
  input  logic                    aud_adclrck,
  input  logic                    aud_adcdat,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  input  logic                    overrun_clear,
  output logic                    frame_error
`ifdef I2S_ADC_PEAK_EN
  ,
  input  logic                    peak_clear,
  output logic [SAMPLE_WIDTH-1:0] peak_left,
  output logic [SAMPLE_WIDTH-1:0] peak_right
`endif
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SHIFT,
    S_WAIT
  } state_t;

  state_t        state, state_n;
  logic [2:0]    bclk_q;
  logic [1:0]    lrck_q, dat_q;
  logic          bclk_rise, lrck_s, dat_s;
  logic          lrck_prev, lrck_chg;
  logic          chan, chan_n;
  logic          have_l, have_n;
  logic          emit_q, emit_n;
  logic          ferr_n;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic [W-2:0]  shreg, shreg_n;
  logic [W-1:0]  word, hold_l, hold_n;
  logic [W-1:0]  word_q, word_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_q <= '0;
      lrck_q <= '0;
      dat_q  <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], aud_bclk};
      lrck_q <= {lrck_q[0], aud_adclrck};
      dat_q  <= {dat_q[0], aud_adcdat};
    end
  end

  assign bclk_rise = bclk_q[1] & ~bclk_q[2];
  assign lrck_s    = lrck_q[1];
  assign dat_s     = dat_q[1];
  assign lrck_chg  = lrck_s != lrck_prev;
  assign word      = {shreg, dat_s};

  always_comb begin
    state_n = state;
    chan_n  = chan;
    cnt_n   = bit_cnt;
    shreg_n = shreg;
    hold_n  = hold_l;
    have_n  = have_l;
    word_n  = word_q;
    emit_n  = 1'b0;
    ferr_n  = 1'b0;
    if (bclk_rise) begin
      if (state != S_IDLE && lrck_chg) begin
        // slot boundary: a word still shifting was cut short
        state_n = S_DELAY;
        chan_n  = lrck_s;
        if (state == S_SHIFT) begin
          ferr_n = 1'b1;
          have_n = 1'b0;
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            if (lrck_prev && !lrck_s) begin
              state_n = S_DELAY;
              chan_n  = 1'b0;
            end
          end
          S_DELAY: begin
            cnt_n   = '0;
            state_n = S_SHIFT;
          end
          S_SHIFT: begin
            shreg_n = word[W-2:0];
            if (bit_cnt == CW'(W - 1)) begin
              state_n = S_WAIT;
              have_n  = 1'b0;
              if (!chan) begin
                hold_n = word;
                have_n = 1'b1;
              end else if (have_l) begin
                emit_n = 1'b1;
                word_n = word;
              end
            end else begin
              cnt_n = bit_cnt + 1'b1;
            end
          end
          S_WAIT: ;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      chan        <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      hold_l      <= '0;
      have_l      <= 1'b0;
      word_q      <= '0;
      emit_q      <= 1'b0;
      frame_error <= 1'b0;
      lrck_prev   <= 1'b1;
    end else begin
      state       <= state_n;
      chan        <= chan_n;
      bit_cnt     <= cnt_n;
      shreg       <= shreg_n;
      hold_l      <= hold_n;
      have_l      <= have_n;
      word_q      <= word_n;
      emit_q      <= emit_n;
      frame_error <= ferr_n;
      if (bclk_rise) lrck_prev <= lrck_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (emit_q) begin
        sample_left  <= hold_l;
        sample_right <= word_q;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      overrun <= (emit_q & sample_valid & ~sample_ready)
               | (overrun & ~overrun_clear);
    end
  end

`ifdef I2S_ADC_PEAK_EN
  logic [W-1:0] mag_l, mag_r, base_l, base_r;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    if (!x[W-1])
      mag = x;
    else if (x == {1'b1, {(W-1){1'b0}}})
      mag = {1'b0, {(W-1){1'b1}}};
    else
      mag = -x;
  endfunction

  assign mag_l  = mag(hold_l);
  assign mag_r  = mag(word_q);
  assign base_l = peak_clear ? '0 : peak_left;
  assign base_r = peak_clear ? '0 : peak_right;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else if (emit_q) begin
      peak_left  <= (mag_l > base_l) ? mag_l : base_l;
      peak_right <= (mag_r > base_r) ? mag_r : base_r;
    end else if (peak_clear) begin
      peak_left  <= '0;
      peak_right <= '0;
    end
  end
`else
  // peak meters not built
`endif

endmodule
